// File: rtl/simmem_release_scheduler.sv
// simmem_release_scheduler
//   Releases messages out of one simmem message bank (write-response or
//   read-data). Each handshake grants at most one enabled slot, chosen
//   round-robin. The granted slot index goes to the bank output stage. The
//   one-hot of the released slot goes back to the delay calculator, which
//   retires that slot.
//
//   Handshake: the offer is out_valid_o/out_addr_o, and a release happens in
//   any cycle with out_valid_o && out_ready_i. Once raised, the offer is never
//   withdrawn. out_addr_o does not change until the handshake completes.
//
// Ports
//   clk_i                  clock
//   rst_i                  synchronous, active-high reset
//   release_en_onehot_i    per-slot release enable (multi-hot)
//   out_ready_i            output stage accepts the offered slot
//   out_valid_o            a slot is being offered
//   out_addr_o             offered slot index
//   released_addr_onehot_o one-hot of the slot released this cycle, else 0
//   busy_o                 offer pending or any slot still inflight
//   release_cnt_o          (SIMMEM_RELEASE_SCHED_STATS_EN) saturating handshake count
//   stall_cnt_o            (SIMMEM_RELEASE_SCHED_STATS_EN) saturating valid&&!ready count
//
// Optional feature macro: SIMMEM_RELEASE_SCHED_STATS_EN

module simmem_release_scheduler #(
    parameter int NumSlots = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumSlots-1:0]         release_en_onehot_i,
    input  logic                        out_ready_i,
    output logic                        out_valid_o,
    output logic [$clog2(NumSlots)-1:0] out_addr_o,
    output logic [NumSlots-1:0]         released_addr_onehot_o,
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
    output logic [31:0]                 release_cnt_o,
    output logic [31:0]                 stall_cnt_o,
`endif
    output logic                        busy_o
);

    localparam int SlotIdxW = $clog2(NumSlots);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [SlotIdxW-1:0]   out_addr_q, out_addr_d;
    logic [SlotIdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NumSlots-1:0]   inflight_q, inflight_d;

    logic                  handshake;
    logic [NumSlots-1:0]   hs_onehot;
    logic [NumSlots-1:0]   eligible;
    logic [NumSlots-1:0]   eligible_after_hs;
    logic [SlotIdxW-1:0]   next_addr;
    logic                  grant_load;
    logic [SlotIdxW-1:0]   grant_idx;

    // Index following idx, wrapping at NumSlots-1 (NumSlots need not be a power of two).
    function automatic logic [SlotIdxW-1:0] inc_idx(input logic [SlotIdxW-1:0] idx);
        if (idx == SlotIdxW'(NumSlots - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Round-robin pick. The vector is duplicated so that a single upward
    // priority search starting at `start` covers the wrap to slot 0.
    function automatic logic [SlotIdxW-1:0] rr_pick(input logic [NumSlots-1:0] vec,
                                                    input logic [SlotIdxW-1:0] start);
        logic [2*NumSlots-1:0] dbl;
        logic [2*NumSlots-1:0] below;
        logic [SlotIdxW:0]     idx;
        dbl   = {vec, vec};
        below = ({{(2*NumSlots-1){1'b0}}, 1'b1} << start) - 1'b1;
        dbl   = dbl & ~below;
        idx   = '0;
        for (int i = 2*NumSlots-1; i >= 0; i--) begin
            if (dbl[i]) begin
                idx = i[SlotIdxW:0];
            end
        end
        if (idx >= (SlotIdxW+1)'(NumSlots)) begin
            idx = idx - (SlotIdxW+1)'(NumSlots);
        end
        return idx[SlotIdxW-1:0];
    endfunction

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            out_addr_q <= '0;
            rr_ptr_q   <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            out_addr_q <= out_addr_d;
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    // The handshake is gated by reset, so no release pulse leaves during a reset cycle.
    assign handshake         = (state_q == OFFER) && out_ready_i && !rst_i;
    assign hs_onehot         = handshake ? (NumSlots'(1) << out_addr_q) : '0;
    assign eligible          = release_en_onehot_i & ~inflight_q;
    assign eligible_after_hs = eligible & ~hs_onehot;
    assign next_addr         = inc_idx(out_addr_q);

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        out_addr_d = out_addr_q;
        rr_ptr_d   = rr_ptr_q;
        grant_load = 1'b0;
        grant_idx  = '0;
        // A bit clears once its enable drops. This covers the calculator's
        // one-cycle enable-clear lag. A new release sets the bit, and the set wins.
        inflight_d = (inflight_q & release_en_onehot_i) | hs_onehot;
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    grant_load = 1'b1;
                    grant_idx  = rr_pick(eligible, rr_ptr_q);
                    out_addr_d = grant_idx;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (handshake) begin
                    rr_ptr_d = next_addr;
                    // Back-to-back re-grant gives one release per cycle.
                    if (|eligible_after_hs) begin
                        grant_load = 1'b1;
                        grant_idx  = rr_pick(eligible_after_hs, next_addr);
                        out_addr_d = grant_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid_o            = (state_q == OFFER);
        out_addr_o             = out_addr_q;
        released_addr_onehot_o = hs_onehot;
        busy_o                 = (state_q == OFFER) || (|inflight_q);
    end

`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
    logic [31:0] release_cnt_q, release_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        release_cnt_d = release_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        if (handshake && (release_cnt_q != '1)) begin
            release_cnt_d = release_cnt_q + 32'd1;
        end
        if ((state_q == OFFER) && !out_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            release_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            release_cnt_q <= release_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign release_cnt_o = release_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;
`endif

    // Protocol and consistency checks
    a_released_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(released_addr_onehot_o));
    a_offer_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_addr_o)));
    a_grant_enabled : assert property (@(posedge clk_i) disable iff (rst_i)
        grant_load |-> release_en_onehot_i[grant_idx]);
    a_no_enable_withdraw : assert property (@(posedge clk_i) disable iff (rst_i)
        out_valid_o |-> release_en_onehot_i[out_addr_o]);

endmodule

// File: tb/tb_simmem_release_scheduler.sv
module tb_simmem_release_scheduler;

    localparam int N = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] release_en_onehot_i;
    logic         out_ready_i;
    logic         out_valid_o;
    logic [2:0]   out_addr_o;
    logic [N-1:0] released_addr_onehot_o;
    logic         busy_o;
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
    logic [31:0]  release_cnt_o;
    logic [31:0]  stall_cnt_o;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    simmem_release_scheduler #(.NumSlots(N)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .release_en_onehot_i    (release_en_onehot_i),
        .out_ready_i            (out_ready_i),
        .out_valid_o            (out_valid_o),
        .out_addr_o             (out_addr_o),
        .released_addr_onehot_o (released_addr_onehot_o),
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
        .release_cnt_o          (release_cnt_o),
        .stall_cnt_o            (stall_cnt_o),
`endif
        .busy_o                 (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        release_en_onehot_i = '0;
        out_ready_i = 1'b0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic expect_offer(input string tag, input logic [2:0] addr, input logic [N-1:0] rel);
        check({tag, "_valid"}, 32'(out_valid_o), 32'd1);
        check({tag, "_addr"}, 32'(out_addr_o), 32'(addr));
        check({tag, "_rel"}, 32'(released_addr_onehot_o), 32'(rel));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, 32'(out_valid_o), 32'd0);
        check({tag, "_rel"}, 32'(released_addr_onehot_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        release_en_onehot_i = '0;
        out_ready_i = 1'b0;
        tick();
        tick();
        #1;
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_addr", 32'(out_addr_o), 32'd0);
        check("rst_rel", 32'(released_addr_onehot_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;

        // Single enable: slot 2 is released once and not re-granted while its enable stays high.
        release_en_onehot_i = 8'b0000_0100;
        out_ready_i = 1'b1;
        #1;
        expect_idle("single_c0");
        tick(); #1;
        expect_offer("single_c1", 3'd2, 8'b0000_0100);
        check("single_c1_busy", 32'(busy_o), 32'd1);
        tick(); #1;
        expect_idle("single_c2");
        check("single_c2_busy", 32'(busy_o), 32'd1);
        tick(); #1;
        expect_idle("single_c3");
        release_en_onehot_i = '0;
        tick(); #1;
        check("single_busy_clear", 32'(busy_o), 32'd0);

        // All-ones: slots 0..7 on consecutive cycles, then idle.
        do_reset();
        release_en_onehot_i = 8'hFF;
        out_ready_i = 1'b1;
        #1;
        expect_idle("all_c0");
        for (int i = 0; i < N; i++) begin
            tick(); #1;
            expect_offer("all_seq", 3'(i), 8'(1 << i));
        end
        tick(); #1;
        expect_idle("all_after");
        tick(); #1;
        expect_idle("all_held");
        release_en_onehot_i = '0;
        tick();
        release_en_onehot_i = 8'hFF;
        #1;
        expect_idle("all_rerise_c0");
        tick(); #1;
        expect_offer("all_rerise", 3'd0, 8'b0000_0001);

        // Backpressure: slot 0 held for 5 stalled cycles, then 0 and 7 released.
        do_reset();
        release_en_onehot_i = 8'b1000_0001;
        out_ready_i = 1'b0;
        #1;
        expect_idle("bp_c0");
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            expect_offer("bp_hold", 3'd0, 8'b0000_0000);
        end
        tick();
        out_ready_i = 1'b1;
        #1;
        expect_offer("bp_rel0", 3'd0, 8'b0000_0001);
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
        check("bp_stall_cnt", stall_cnt_o, 32'd5);
`endif
        tick(); #1;
        expect_offer("bp_rel7", 3'd7, 8'b1000_0000);
        tick(); #1;
        expect_idle("bp_done");
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
        check("bp_release_cnt", release_cnt_o, 32'd2);
        check("bp_stall_final", stall_cnt_o, 32'd5);
`endif

        // Wrap: after releasing slot 6, the pointer sits at 7, so 7 goes before 0.
        do_reset();
        release_en_onehot_i = 8'b0100_0000;
        out_ready_i = 1'b1;
        tick(); #1;
        expect_offer("wrap_rel6", 3'd6, 8'b0100_0000);
        tick();
        release_en_onehot_i = '0;
        tick();
        release_en_onehot_i = 8'b1000_0001;
        tick(); #1;
        expect_offer("wrap_rel7", 3'd7, 8'b1000_0000);
        tick(); #1;
        expect_offer("wrap_rel0", 3'd0, 8'b0000_0001);
        tick(); #1;
        expect_idle("wrap_done");

        // Inflight lag: slot 3 is not re-granted until its enable drops and rises again.
        do_reset();
        release_en_onehot_i = 8'b0000_1000;
        out_ready_i = 1'b1;
        tick(); #1;
        expect_offer("lag_rel3", 3'd3, 8'b0000_1000);
        tick(); #1;
        expect_idle("lag_hold1");
        tick(); #1;
        expect_idle("lag_hold2");
        release_en_onehot_i = '0;
        tick();
        release_en_onehot_i = 8'b0000_1000;
        #1;
        expect_idle("lag_rerise_c0");
        tick(); #1;
        expect_offer("lag_regrant", 3'd3, 8'b0000_1000);

        // Reset mid-OFFER: no release pulse during reset, then slot 5 is offered again.
        do_reset();
        release_en_onehot_i = 8'b0010_0000;
        out_ready_i = 1'b0;
        tick(); #1;
        expect_offer("rst_mid_offer", 3'd5, 8'b0000_0000);
        tick();
        rst_i = 1'b1;
        out_ready_i = 1'b1;
        #1;
        check("rst_mid_no_pulse", 32'(released_addr_onehot_o), 32'd0);
        tick();
        rst_i = 1'b0;
        #1;
        expect_idle("rst_mid_after");
        check("rst_mid_busy", 32'(busy_o), 32'd0);
`ifdef SIMMEM_RELEASE_SCHED_STATS_EN
        check("rst_mid_release_cnt", release_cnt_o, 32'd0);
        check("rst_mid_stall_cnt", stall_cnt_o, 32'd0);
`endif
        tick(); #1;
        expect_offer("rst_mid_reoffer", 3'd5, 8'b0010_0000);
        tick(); #1;
        expect_idle("rst_mid_done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
